// File: rtl/fs_16bit.sv
// Registered 16-bit subtractor: a - b - bin through a ripple chain of sixteen
// 1-bit full-subtractor cells, with the difference and borrow-out captured on clk.

module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    logic axb;

    assign axb = a ^ b;
    assign d   = axb ^ bi;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending
    assign bo  = (~a & b) | (~axb & bi);
endmodule

module fs_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    output logic [15:0] diff,
    output logic        bout
);
    logic [16:0] br;
    logic [15:0] diff_next;

    assign br[0] = bin;

    for (genvar i = 0; i < 16; i++) begin : g_cell
        fs_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .bi (br[i]),
            .d  (diff_next[i]),
            .bo (br[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            diff <= 16'h0000;
            bout <= 1'b0;
        end else begin
            diff <= diff_next;
            bout <= br[16];
        end
    end
endmodule

// File: tb/tb_fs_16bit.sv
// Bench for fs_16bit: directed vectors, boundaries, latency checks and a
// randomized run against a 17-bit arithmetic reference.

module tb_fs_16bit;
    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;

    int passed = 0;
    int total  = 0;

    fs_16bit dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .diff (diff),
        .bout (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    function automatic logic [16:0] ref_sub(input logic [15:0] ra, input logic [15:0] rb,
                                            input logic rbin);
        logic [16:0] r;
        r = {1'b0, ra} - {1'b0, rb} - {16'h0000, rbin};
        return r;
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed bout/diff=%h expected %h", tag, obs, exp);
    endtask

    // Apply one vector, clock it in, then check the registered result
    task automatic step(input string tag, input logic r, input logic [15:0] va,
                        input logic [15:0] vb, input logic vbin);
        logic [16:0] exp;
        rst = r;
        a   = va;
        b   = vb;
        bin = vbin;
        exp = r ? 17'h0_0000 : ref_sub(va, vb, vbin);
        @(posedge clk);
        #1;
        check(tag, {bout, diff}, exp);
    endtask

    logic [15:0] ha [8];
    logic [15:0] hb [8];
    logic        hbin [8];

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        bin = 1'b0;
        @(negedge clk);

        step("reset0", 1'b1, 16'h1234, 16'h0001, 1'b1);
        step("reset1", 1'b1, 16'h1234, 16'h0001, 1'b1);
        check("reset_const", {bout, diff}, 17'h0_0000);
        step("release", 1'b0, 16'h1234, 16'h0001, 1'b1);
        check("release_const", {bout, diff}, {1'b0, 16'h1232});

        step("bin1_a", 1'b0, 16'h0000, 16'h0000, 1'b1);
        check("bin1_a_const", {bout, diff}, {1'b1, 16'hFFFF});
        step("bin1_b", 1'b0, 16'h0001, 16'h00F0, 1'b1);
        check("bin1_b_const", {bout, diff}, {1'b1, 16'hFF10});
        step("bin1_c", 1'b0, 16'h0002, 16'h1000, 1'b1);
        check("bin1_c_const", {bout, diff}, {1'b1, 16'hF001});
        step("bin1_d", 1'b0, 16'h0003, 16'h0030, 1'b1);
        check("bin1_d_const", {bout, diff}, {1'b1, 16'hFFD2});
        step("bin1_e", 1'b0, 16'h0040, 16'h0001, 1'b1);
        check("bin1_e_const", {bout, diff}, {1'b0, 16'h003E});

        step("bin0_a", 1'b0, 16'h0000, 16'h0000, 1'b0);
        check("bin0_a_const", {bout, diff}, {1'b0, 16'h0000});
        step("bin0_b", 1'b0, 16'h0001, 16'h00F0, 1'b0);
        check("bin0_b_const", {bout, diff}, {1'b1, 16'hFF11});
        step("bin0_c", 1'b0, 16'h0002, 16'h1000, 1'b0);
        check("bin0_c_const", {bout, diff}, {1'b1, 16'hF002});
        step("bin0_d", 1'b0, 16'h0003, 16'h0030, 1'b0);
        check("bin0_d_const", {bout, diff}, {1'b1, 16'hFFD3});
        step("bin0_e", 1'b0, 16'h0040, 16'h0001, 1'b0);
        check("bin0_e_const", {bout, diff}, {1'b0, 16'h003F});

        step("bnd_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        check("bnd_ffff_ffff_const", {bout, diff}, {1'b1, 16'hFFFF});
        step("bnd_ffff_0000", 1'b0, 16'hFFFF, 16'h0000, 1'b0);
        check("bnd_ffff_0000_const", {bout, diff}, {1'b0, 16'hFFFF});
        step("bnd_8000_0001", 1'b0, 16'h8000, 16'h0001, 1'b0);
        check("bnd_8000_0001_const", {bout, diff}, {1'b0, 16'h7FFF});
        step("bnd_0000_ffff", 1'b0, 16'h0000, 16'hFFFF, 1'b1);
        check("bnd_0000_ffff_const", {bout, diff}, {1'b1, 16'h0000});

        // Back-to-back: each output reflects the inputs present at the previous edge
        for (int i = 0; i < 8; i++) begin
            ha[i]   = 16'($urandom);
            hb[i]   = 16'($urandom);
            hbin[i] = 1'($urandom);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a   = ha[i];
            b   = hb[i];
            bin = hbin[i];
            @(posedge clk);
            #1;
            check("b2b", {bout, diff}, ref_sub(ha[i], hb[i], hbin[i]));
            // Mid-cycle toggling must not reach the outputs before the next edge
            a   = ~ha[i];
            b   = ha[i];
            bin = ~hbin[i];
            #2;
            check("hold", {bout, diff}, ref_sub(ha[i], hb[i], hbin[i]));
        end

        for (int i = 0; i < 10000; i++) begin
            step("random", ($urandom_range(99) < 5), 16'($urandom), 16'($urandom),
                 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fs_16bit.md
# fs_16bit

Registered 16-bit full subtractor. It computes `a - b - bin` as a ripple chain of sixteen 1-bit full-subtractor cells and produces a 16-bit difference and a borrow-out. Outputs are registered on one clock, so the block drops into any synchronous datapath stage (ALU subtract path, comparator, decrement logic). Inputs are fully combinational into the chain; only the result is stored.

## Interface
- No parameters; width fixed at 16.
- `clk`  input  1  rising-edge clock; sole clock of the block.
- `rst`  input  1  synchronous, active-high reset.
- `a`  input  16  minuend, unsigned.
- `b`  input  16  subtrahend, unsigned.
- `bin`  input  1  borrow-in, subtracted at bit 0.
- `diff`  output  16  registered difference, `(a - b - bin) mod 2^16`.
- `bout`  output  1  registered borrow-out from bit 15.

## Operation
- Bit cell i (i = 0..15), with borrow-in `br[i]` and `br[0] = bin`:
  - `d[i] = a[i] ^ b[i] ^ br[i]`
  - `br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i])`
- Next-state values:
  - `diff_next = d[15:0]`
  - `bout_next = br[16]`
- Arithmetic equivalence: `{bout_next, diff_next} = {1'b0, a} - {1'b0, b} - bin`, taken in 17-bit two's complement.
- `bout_next = 1` exactly when `a < b + bin` (unsigned, with the sum evaluated in 17 bits).
- The ripple structure is required: one 1-bit cell instantiated 16 times (generate loop or explicit instances). A behavioural `-` is permitted only in verification models.
- No overflow or sign flags. Signed interpretation is left to the consumer (signed overflow = `a[15] ^ b[15]` and `a[15] ^ diff[15]`, computed externally).
- Wrap-around boundaries:
  - `a = 0, b = 0, bin = 1` -> `diff = FFFF`, `bout = 1`
  - `a = 0, b = FFFF, bin = 1` -> `diff = 0000`, `bout = 1`
  - `a = FFFF, b = 0, bin = 0` -> `diff = FFFF`, `bout = 0`
- X/Z on inputs propagates into the result; there is no input qualification and no valid signal.

## Timing
- On every rising `clk` edge with `rst = 0`, `diff <= diff_next` and `bout <= bout_next`. Latency is exactly 1 cycle; throughput is one result per cycle.
- Reset:
  - On a rising edge with `rst = 1`, `diff <= 16'h0000` and `bout <= 0`, regardless of `a`, `b` and `bin`.
  - `rst` has priority over new data.
  - The first edge after `rst` deasserts captures whatever inputs are present at that edge.
- Reset mid-stream discards the in-flight result. No state survives other than the output registers.
- Before the first clock edge, the outputs are unknown (no initial values are relied on).
- Combinational path: `a`, `b` and `bin` to the `diff`/`bout` D inputs through 16 cells of borrow ripple. This path must close timing within one `clk` period. There is no path from the inputs to the outputs that bypasses the registers.
- Input changes between edges have no effect on the outputs until the next edge.

## Test plan
- **Reset:** hold `rst = 1` for 2 cycles with `a = 1234`, `b = 0001`, `bin = 1` -> `diff = 0000`, `bout = 0` after each edge. Release `rst` -> next edge gives `diff = 1232`, `bout = 0`.
- **`bin = 1` directed set** (one vector per cycle, result checked one edge later):
  - `0000-0000` -> `FFFF`/1
  - `0001-00F0` -> `FF10`/1
  - `0002-1000` -> `F001`/1
  - `0003-0030` -> `FFD2`/1
  - `0040-0001` -> `003E`/0
- **`bin = 0` directed set:**
  - `0000-0000` -> `0000`/0
  - `0001-00F0` -> `FF11`/1
  - `0002-1000` -> `F002`/1
  - `0003-0030` -> `FFD3`/1
  - `0040-0001` -> `003F`/0
- **Boundaries:**
  - `FFFF-FFFF`, `bin = 1` -> `FFFF`/1
  - `FFFF-0000`, `bin = 0` -> `FFFF`/0
  - `8000-0001`, `bin = 0` -> `7FFF`/0
  - `0000-FFFF`, `bin = 1` -> `0000`/1
- **Latency/back-to-back:** change inputs every cycle for 8 cycles -> each output equals the previous edge's inputs. Toggling inputs mid-cycle does not change the outputs.
- **Random:** at least 10k random `a`, `b`, `bin` -> registered result matches the 17-bit reference `{bout, diff} = a - b - bin`. Assert `rst` randomly at about 5% and check that the outputs clear on that edge.
